// File: rtl/playback_pkg.sv
// Shared types for the flash-playback address controller.
//   state_t : controller FSM states (PAUSE, WAIT, READ)
//   DIR_FW / DIR_BW : encodings of the dir output
package playback_pkg;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,  // stopped, address held
        WAIT  = 2'd1,  // playing, waiting for the next sample_tick
        READ  = 2'd2   // mem_req high, waiting for mem_ack
    } state_t;

    localparam logic DIR_FW = 1'b0;
    localparam logic DIR_BW = 1'b1;

endpackage

// File: rtl/playback_addr_step.sv
// Combinational next-address calculator with bidirectional wrap-around.
//   addr      in  ADDR_W  current address
//   dir       in  1       DIR_FW / DIR_BW
//   next_addr out ADDR_W  address after one STEP in direction dir
//   wrap      out 1       high when the wrap branch was taken
module playback_addr_step
    import playback_pkg::*;
#(
    parameter int unsigned           ADDR_W     = 23,
    parameter logic [ADDR_W-1:0]     START_ADDR = '0,
    parameter logic [ADDR_W-1:0]     END_ADDR   = 23'h7FFFF,
    parameter int unsigned           STEP       = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              dir,
    output logic [ADDR_W-1:0] next_addr,
    output logic              wrap
);

    // One extra bit so neither END-STEP nor addr+STEP can overflow.
    localparam logic [ADDR_W:0] START_W  = {1'b0, START_ADDR};
    localparam logic [ADDR_W:0] END_W    = {1'b0, END_ADDR};
    localparam logic [ADDR_W:0] STEP_W   = (ADDR_W+1)'(STEP);
    localparam logic [ADDR_W:0] FW_LIMIT = END_W - STEP_W;
    localparam logic [ADDR_W:0] BW_LIMIT = START_W + STEP_W;

    logic [ADDR_W:0] addr_w;
    logic [ADDR_W:0] sum_w;

    always_comb begin
        addr_w = {1'b0, addr};
        sum_w  = addr_w;
        wrap   = 1'b0;
        if (dir == DIR_FW) begin
            if (addr_w > FW_LIMIT) begin
                sum_w = START_W;
                wrap  = 1'b1;
            end else begin
                sum_w = addr_w + STEP_W;
            end
        end else begin
            if (addr_w < BW_LIMIT) begin
                sum_w = END_W;
                wrap  = 1'b1;
            end else begin
                sum_w = addr_w - STEP_W;
            end
        end
        next_addr = sum_w[ADDR_W-1:0];
    end

endmodule

// File: rtl/playback_addr_ctrl.sv
// Flash-playback address controller: turns keyboard pulses into a sample
// address that advances once per acknowledged flash read.
//   clk, rst_n            clock, async active-low reset
//   key_e/d/f/b/r         play / pause / forward / backward / restart pulses
//   sample_tick           audio-rate pulse; starts a read while playing
//   mem_ack, mem_req      flash read handshake
//   addr, dir, playing    current address, direction, playing status
//   sample_valid, wrapped, overrun   single-cycle event pulses
//   dbg_state             current FSM state
//
// Handshake: mem_req rises the cycle after an accepted sample_tick and is a
// level held until mem_ack is sampled high; addr does not change while
// mem_req is high. mem_ack is a one-cycle pulse and is ignored unless a
// request is outstanding. The read is never abandoned except by reset.
module playback_addr_ctrl
    import playback_pkg::*;
#(
    parameter int unsigned           ADDR_W     = 23,
    parameter logic [ADDR_W-1:0]     START_ADDR = '0,
    parameter logic [ADDR_W-1:0]     END_ADDR   = 23'h7FFFF,
    parameter int unsigned           STEP       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_e,
    input  logic              key_d,
    input  logic              key_f,
    input  logic              key_b,
    input  logic              key_r,
    input  logic              sample_tick,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] addr,
    output logic              dir,
    output logic              playing,
    output logic              sample_valid,
    output logic              wrapped,
    output logic              overrun,
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dir_q, dir_d;
    logic              pause_pend_q, pause_pend_d;
    logic              restart_pend_q, restart_pend_d;
    logic              mem_req_q, playing_q;
    logic              sample_valid_q, sample_valid_d;
    logic              wrapped_q, wrapped_d;
    logic              overrun_q, overrun_d;

    logic              restart_req, pause_req, play_req;
    logic [ADDR_W-1:0] restart_addr;
    logic [ADDR_W-1:0] step_addr;
    logic              step_wrap;

    // Only the highest-priority of r > d > e acts in a given cycle.
    assign restart_req = key_r;
    assign pause_req   = key_d & ~key_r;
    assign play_req    = key_e & ~key_d & ~key_r;

    // Simultaneous forward+backward cancel out and keep the old direction.
    always_comb begin
        dir_d = dir_q;
        if (key_f && !key_b) dir_d = DIR_FW;
        else if (key_b && !key_f) dir_d = DIR_BW;
    end

    // Restart follows the direction that will be in force next cycle.
    assign restart_addr = (dir_d == DIR_BW) ? END_ADDR : START_ADDR;

    playback_addr_step #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR),
        .STEP       (STEP)
    ) u_step (
        .addr      (addr_q),
        .dir       (dir_q),
        .next_addr (step_addr),
        .wrap      (step_wrap)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        pause_pend_d   = pause_pend_q;
        restart_pend_d = restart_pend_q;
        sample_valid_d = 1'b0;
        wrapped_d      = 1'b0;
        overrun_d      = 1'b0;
        unique case (state_q)
            PAUSE: begin
                if (restart_req)   addr_d  = restart_addr;
                else if (play_req) state_d = WAIT;
            end
            WAIT: begin
                if (restart_req)    addr_d  = restart_addr;
                else if (pause_req) state_d = PAUSE;
                // A pause in the same cycle as a tick wins over the read.
                if (sample_tick && !pause_req) state_d = READ;
            end
            READ: begin
                if (sample_tick) overrun_d = 1'b1;
                if (mem_ack) begin
                    sample_valid_d = 1'b1;
                    // Pending (or same-cycle) keys are folded into the ack.
                    if (restart_pend_q || restart_req) begin
                        addr_d = restart_addr;
                    end else begin
                        addr_d    = step_addr;
                        wrapped_d = step_wrap;
                    end
                    state_d        = (pause_pend_q || pause_req) ? PAUSE : WAIT;
                    pause_pend_d   = 1'b0;
                    restart_pend_d = 1'b0;
                end else begin
                    if (restart_req) restart_pend_d = 1'b1;
                    if (pause_req)   pause_pend_d   = 1'b1;
                end
            end
            default: state_d = PAUSE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= PAUSE;
            addr_q         <= START_ADDR;
            dir_q          <= DIR_FW;
            pause_pend_q   <= 1'b0;
            restart_pend_q <= 1'b0;
            mem_req_q      <= 1'b0;
            playing_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            wrapped_q      <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            dir_q          <= dir_d;
            pause_pend_q   <= pause_pend_d;
            restart_pend_q <= restart_pend_d;
            mem_req_q      <= (state_d == READ);
            playing_q      <= (state_d != PAUSE);
            sample_valid_q <= sample_valid_d;
            wrapped_q      <= wrapped_d;
            overrun_q      <= overrun_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign addr         = addr_q;
    assign dir          = dir_q;
    assign playing      = playing_q;
    assign sample_valid = sample_valid_q;
    assign wrapped      = wrapped_q;
    assign overrun      = overrun_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_playback_addr_ctrl.sv
module tb_playback_addr_ctrl;
    import playback_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: START=0, END=7, STEP=1
    logic        a_key_e, a_key_d, a_key_f, a_key_b, a_key_r, a_tick, a_ack;
    logic        a_mem_req, a_dir, a_playing, a_sv, a_wrapped, a_overrun;
    logic [22:0] a_addr;
    state_t      a_state;

    // Instance B: START=0, END=10, STEP=4
    logic        b_key_e, b_key_d, b_key_f, b_key_b, b_key_r, b_tick, b_ack;
    logic        b_mem_req, b_dir, b_playing, b_sv, b_wrapped, b_overrun;
    logic [22:0] b_addr;
    state_t      b_state;

    playback_addr_ctrl #(
        .ADDR_W(23), .START_ADDR(23'd0), .END_ADDR(23'd7), .STEP(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n),
        .key_e(a_key_e), .key_d(a_key_d), .key_f(a_key_f), .key_b(a_key_b), .key_r(a_key_r),
        .sample_tick(a_tick), .mem_ack(a_ack),
        .mem_req(a_mem_req), .addr(a_addr), .dir(a_dir), .playing(a_playing),
        .sample_valid(a_sv), .wrapped(a_wrapped), .overrun(a_overrun), .dbg_state(a_state)
    );

    playback_addr_ctrl #(
        .ADDR_W(23), .START_ADDR(23'd0), .END_ADDR(23'd10), .STEP(4)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .key_e(b_key_e), .key_d(b_key_d), .key_f(b_key_f), .key_b(b_key_b), .key_r(b_key_r),
        .sample_tick(b_tick), .mem_ack(b_ack),
        .mem_req(b_mem_req), .addr(b_addr), .dir(b_dir), .playing(b_playing),
        .sample_valid(b_sv), .wrapped(b_wrapped), .overrun(b_overrun), .dbg_state(b_state)
    );

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a(input int wait_cyc);
        a_tick = 1'b1; cyc(); a_tick = 1'b0;
        repeat (wait_cyc - 1) cyc();
        a_ack = 1'b1; cyc(); a_ack = 1'b0;
    endtask

    task automatic read_b(input int wait_cyc);
        b_tick = 1'b1; cyc(); b_tick = 1'b0;
        repeat (wait_cyc - 1) cyc();
        b_ack = 1'b1; cyc(); b_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        {a_key_e, a_key_d, a_key_f, a_key_b, a_key_r, a_tick, a_ack} = '0;
        {b_key_e, b_key_d, b_key_f, b_key_b, b_key_r, b_tick, b_ack} = '0;
        repeat (2) cyc();
        n_tests++; if (a_addr !== 23'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", a_addr); end
        n_tests++; if (a_dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir got %b want 0", a_dir); end
        n_tests++; if ({a_mem_req, a_playing, a_sv, a_wrapped, a_overrun} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got %b want 00000", {a_mem_req, a_playing, a_sv, a_wrapped, a_overrun}); end
        n_tests++; if (a_state !== PAUSE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", a_state, PAUSE); end
        n_tests++; if (b_addr !== 23'd0 || b_state !== PAUSE) begin
            n_fail++; $display("FAIL reset_b got addr %0d state %0d want 0/%0d", b_addr, b_state, PAUSE); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_play_steps();
        int sv_count = 0;
        a_key_e = 1'b1; cyc(); a_key_e = 1'b0;
        n_tests++; if (a_playing !== 1'b1 || a_state !== WAIT) begin
            n_fail++; $display("FAIL play_key got playing %b state %0d want 1/%0d", a_playing, a_state, WAIT); end
        for (int i = 1; i <= 3; i++) begin
            a_tick = 1'b1; cyc(); a_tick = 1'b0;
            n_tests++; if (a_mem_req !== 1'b1 || a_addr !== 23'(i - 1)) begin
                n_fail++; $display("FAIL req1_%0d got req %b addr %0d want 1/%0d", i, a_mem_req, a_addr, i - 1); end
            cyc();
            n_tests++; if (a_mem_req !== 1'b1) begin n_fail++; $display("FAIL req2_%0d got %b want 1", i, a_mem_req); end
            a_ack = 1'b1; cyc(); a_ack = 1'b0;
            if (a_sv === 1'b1) sv_count++;
            n_tests++; if (a_mem_req !== 1'b0 || a_addr !== 23'(i)) begin
                n_fail++; $display("FAIL ack_%0d got req %b addr %0d want 0/%0d", i, a_mem_req, a_addr, i); end
            cyc();
            n_tests++; if (a_sv !== 1'b0) begin n_fail++; $display("FAIL sv_pulse_%0d got %b want 0", i, a_sv); end
        end
        n_tests++; if (sv_count != 3) begin n_fail++; $display("FAIL sv_count got %0d want 3", sv_count); end
    endtask

    task automatic test_wrap();
        repeat (4) begin read_a(2); cyc(); end
        n_tests++; if (a_addr !== 23'd7) begin n_fail++; $display("FAIL pre_wrap got %0d want 7", a_addr); end
        read_a(2);
        n_tests++; if (a_addr !== 23'd0 || a_wrapped !== 1'b1) begin
            n_fail++; $display("FAIL fw_wrap got addr %0d wrapped %b want 0/1", a_addr, a_wrapped); end
        cyc();
        n_tests++; if (a_wrapped !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse got %b want 0", a_wrapped); end
        a_key_b = 1'b1; cyc(); a_key_b = 1'b0;
        n_tests++; if (a_dir !== 1'b1) begin n_fail++; $display("FAIL key_b got %b want 1", a_dir); end
        read_a(2);
        n_tests++; if (a_addr !== 23'd7 || a_wrapped !== 1'b1) begin
            n_fail++; $display("FAIL bw_wrap got addr %0d wrapped %b want 7/1", a_addr, a_wrapped); end
        cyc();
    endtask

    task automatic test_pause_restart_in_read();
        read_a(2); cyc();
        read_a(2); cyc();
        n_tests++; if (a_addr !== 23'd5) begin n_fail++; $display("FAIL pre_pr_addr got %0d want 5", a_addr); end
        a_key_f = 1'b1; cyc(); a_key_f = 1'b0;
        a_tick = 1'b1; cyc(); a_tick = 1'b0;
        a_key_d = 1'b1; cyc(); a_key_d = 1'b0;
        a_key_r = 1'b1; cyc(); a_key_r = 1'b0;
        n_tests++; if (a_mem_req !== 1'b1 || a_addr !== 23'd5 || a_state !== READ) begin
            n_fail++; $display("FAIL read_hold got req %b addr %0d state %0d want 1/5/%0d", a_mem_req, a_addr, a_state, READ); end
        cyc();
        a_ack = 1'b1; cyc(); a_ack = 1'b0;
        n_tests++; if (a_mem_req !== 1'b0 || a_addr !== 23'd0) begin
            n_fail++; $display("FAIL pend_apply got req %b addr %0d want 0/0", a_mem_req, a_addr); end
        n_tests++; if (a_state !== PAUSE || a_playing !== 1'b0 || a_sv !== 1'b1 || a_wrapped !== 1'b0) begin
            n_fail++; $display("FAIL pend_state got state %0d playing %b sv %b wrapped %b want %0d/0/1/0",
                               a_state, a_playing, a_sv, a_wrapped, PAUSE); end
        cyc();
    endtask

    task automatic test_overrun();
        a_key_e = 1'b1; cyc(); a_key_e = 1'b0;
        a_tick = 1'b1; cyc(); cyc(); a_tick = 1'b0;
        n_tests++; if (a_overrun !== 1'b1 || a_mem_req !== 1'b1) begin
            n_fail++; $display("FAIL overrun got ov %b req %b want 1/1", a_overrun, a_mem_req); end
        cyc();
        n_tests++; if (a_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_pulse got %b want 0", a_overrun); end
        a_ack = 1'b1; cyc(); a_ack = 1'b0;
        n_tests++; if (a_addr !== 23'd1 || a_sv !== 1'b1) begin
            n_fail++; $display("FAIL overrun_step got addr %0d sv %b want 1/1", a_addr, a_sv); end
        cyc(); cyc();
        n_tests++; if (a_mem_req !== 1'b0 || a_state !== WAIT || a_addr !== 23'd1) begin
            n_fail++; $display("FAIL no_extra_read got req %b state %0d addr %0d want 0/%0d/1", a_mem_req, a_state, a_addr, WAIT); end
    endtask

    task automatic test_dir_keys();
        a_key_b = 1'b1; cyc(); a_key_b = 1'b0;
        a_key_f = 1'b1; a_key_b = 1'b1; cyc(); a_key_f = 1'b0; a_key_b = 1'b0;
        n_tests++; if (a_dir !== 1'b1) begin n_fail++; $display("FAIL fb_same_cycle got %b want 1", a_dir); end
        a_key_f = 1'b1; cyc(); a_key_f = 1'b0;
        n_tests++; if (a_dir !== 1'b0) begin n_fail++; $display("FAIL key_f got %b want 0", a_dir); end
        a_key_r = 1'b1; a_key_b = 1'b1; cyc(); a_key_r = 1'b0; a_key_b = 1'b0;
        n_tests++; if (a_dir !== 1'b1 || a_addr !== 23'd7 || a_state !== WAIT) begin
            n_fail++; $display("FAIL rb_same_cycle got dir %b addr %0d state %0d want 1/7/%0d", a_dir, a_addr, a_state, WAIT); end
    endtask

    task automatic test_step4();
        int fw_addr[3] = '{4, 8, 0};
        int fw_wrap[3] = '{0, 0, 1};
        int bw_addr[4] = '{10, 6, 2, 10};
        int bw_wrap[4] = '{1, 0, 0, 1};
        b_key_e = 1'b1; cyc(); b_key_e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            read_b(2);
            n_tests++; if (b_addr !== 23'(fw_addr[i]) || b_wrapped !== 1'(fw_wrap[i])) begin
                n_fail++; $display("FAIL s4_fw_%0d got addr %0d wrapped %b want %0d/%0d", i, b_addr, b_wrapped, fw_addr[i], fw_wrap[i]); end
            cyc();
        end
        b_key_b = 1'b1; cyc(); b_key_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_b(2);
            n_tests++; if (b_addr !== 23'(bw_addr[i]) || b_wrapped !== 1'(bw_wrap[i])) begin
                n_fail++; $display("FAIL s4_bw_%0d got addr %0d wrapped %b want %0d/%0d", i, b_addr, b_wrapped, bw_addr[i], bw_wrap[i]); end
            cyc();
        end
    endtask

    task automatic test_async_reset();
        a_tick = 1'b1; b_tick = 1'b1; cyc(); a_tick = 1'b0; b_tick = 1'b0;
        n_tests++; if (b_mem_req !== 1'b1 || a_mem_req !== 1'b1) begin
            n_fail++; $display("FAIL pre_rst_req got a %b b %b want 1/1", a_mem_req, b_mem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({b_mem_req, b_playing, b_dir, b_sv, b_wrapped, b_overrun} !== 6'b0 || b_addr !== 23'd0 || b_state !== PAUSE) begin
            n_fail++; $display("FAIL async_rst_b got req %b play %b dir %b addr %0d state %0d want 0/0/0/0/%0d",
                               b_mem_req, b_playing, b_dir, b_addr, b_state, PAUSE); end
        n_tests++; if (a_mem_req !== 1'b0 || a_addr !== 23'd0 || a_dir !== 1'b0 || a_state !== PAUSE) begin
            n_fail++; $display("FAIL async_rst_a got req %b addr %0d dir %b state %0d want 0/0/0/%0d",
                               a_mem_req, a_addr, a_dir, a_state, PAUSE); end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_play_steps();
        test_wrap();
        test_pause_restart_in_read();
        test_overrun();
        test_dir_keys();
        test_step4();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/playback_addr_ctrl.md
# playback_addr_ctrl

Parametrised flash-playback address controller for the audio path. Translates decoded keyboard commands (play, pause, forward, backward, restart) into a sample address that advances at the audio sample rate. Each address is fetched through a request/acknowledge handshake with the flash reader. Sits between the keyboard decoder and the flash read FSM; generalises the fixed 32-bit play/pause/direction logic with configurable bounds, step size, bidirectional wrap-around, a memory handshake and overrun detection.

## Interface
- ADDR_W, 23: address width in bits.
- START_ADDR, 0: first playable address (inclusive).
- END_ADDR, 23'h7FFFF: last playable address (inclusive); must be > START_ADDR.
- STEP, 1: address increment per sample; must be ≥1 and ≤ END_ADDR−START_ADDR.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_e  in  1  play pulse (1 cycle).
- key_d  in  1  pause pulse.
- key_f  in  1  select forward pulse.
- key_b  in  1  select backward pulse.
- key_r  in  1  restart pulse.
- sample_tick  in  1  one-cycle pulse at the audio sample rate.
- mem_ack  in  1  flash read complete; 1-cycle pulse.
- mem_req  out  1  read request for addr; level, held until mem_ack.
- addr  out  ADDR_W  current sample address.
- dir  out  1  0 = forward, 1 = backward.
- playing  out  1  high in WAIT and READ states.
- sample_valid  out  1  1-cycle pulse the cycle after mem_ack.
- wrapped  out  1  1-cycle pulse when a step wrapped the address.
- overrun  out  1  1-cycle pulse when sample_tick arrives while in READ.

## Operation
- States: PAUSE, WAIT (playing, awaiting tick), READ (mem_req high, awaiting ack).
- PAUSE: key_e → WAIT. WAIT: sample_tick → READ. WAIT: key_d → PAUSE. READ: mem_ack → WAIT, or PAUSE if a pause is pending.
- Key priority in one cycle: key_r > key_d > key_e. key_f and key_b together are ignored; the direction is unchanged.
- key_f/key_b update dir in any state; the new direction applies from the next step.
- Restart loads START_ADDR if the effective dir is 0, or END_ADDR if it is 1. The effective dir includes a same-cycle key_f/key_b. Restart does not change the state.
- The READ state is never aborted:
  - key_d in READ sets pause_pend.
  - key_r in READ sets restart_pend.
  - Both pending flags are applied on mem_ack and cleared by it.
  - When restart_pend is set, the restart load replaces the step.
- Step on mem_ack:
  - Forward: addr > END_ADDR−STEP → START_ADDR, else addr+STEP.
  - Backward: addr < START_ADDR+STEP → END_ADDR, else addr−STEP.
  - wrapped pulses when a wrap branch is taken.
- Arithmetic is done at ADDR_W+1 bits so no intermediate value overflows.
- sample_tick in READ asserts overrun, and the tick is dropped (not queued). sample_tick in PAUSE is ignored.
- mem_ack outside READ is ignored.

## Timing
- Reset values: addr=START_ADDR, dir=0, state=PAUSE, mem_req=0, playing=0, sample_valid=0, wrapped=0, overrun=0, pending flags=0.
- All outputs are registered.
- Key effects are visible the cycle after the pulse.
- mem_req rises the cycle after the accepted sample_tick.
- addr is stable for the entire time mem_req is high.
- On mem_ack (cycle N):
  - Cycle N+1: mem_req=0, addr is updated, sample_valid=1, wrapped asserted if applicable.
- The minimum tick-to-next-request spacing is 3 cycles.
- Reset asserted mid-READ drops mem_req immediately (asynchronously); the flash reader must tolerate an abandoned request.

## Structure
- playback_pkg holds:
  - the state enum type (PAUSE, WAIT, READ);
  - the dir constants DIR_FW/DIR_BW.
- Sub-module playback_addr_step (combinational):
  - parameters: ADDR_W, START_ADDR, END_ADDR, STEP;
  - inputs: addr, dir;
  - outputs: next_addr, wrap.
  - It is instantiated once and unit-testable on its own.
- The FSM, key decode, pending flags and output registers live in the top module.

## Test plan
- Reset, key_e, 3 ticks each acked after 2 cycles (STEP=1, START=0) → addr 0→1→2→3, three sample_valid pulses, mem_req high exactly 2 cycles each time.
- START=0, END=7, addr=7, forward, tick+ack → addr=0 and wrapped=1. key_b, tick+ack → addr=7 and wrapped=1.
- key_d and key_r during READ (addr=5), with ack 4 cycles later → mem_req held until ack, addr=START_ADDR, state=PAUSE, no step applied.
- Second sample_tick while mem_req is high → overrun for 1 cycle, only one step after ack, no extra READ.
- key_f+key_b in the same cycle → dir unchanged. key_r+key_b in the same cycle → dir=1 and addr=END_ADDR.
- STEP=4, START=0, END=10, forward from 8 → wraps to 0. Backward from 2 → wraps to 10. Assert rst_n low mid-READ → all outputs return to reset values without waiting for a clock edge.
